// File: rtl/e_mdu.sv
// Iterative multiply/divide unit for the E stage: radix-2 shift-add multiply,
// restoring divide, and direct HI/LO writes. One iteration per cycle.
module e_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  logic [1:0]         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic               is_div_reg;
  logic               sign_a_reg;
  logic               sign_b_reg;
  logic               div_zero_reg;
  logic               busy_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  // Operand preparation; an unsigned WIDTH-bit magnitude already holds |MIN|.
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // Restoring divide step: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

  // Sign correction applied in FIX.
  logic               neg_result;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  assign neg_result = sign_a_reg ^ sign_b_reg;
  assign prod_fixed = neg_result ? -acc_reg : acc_reg;
  assign rem_fixed  = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
  // A zero divisor leaves |a| as the remainder, so only the quotient needs forcing.
  assign quot_fixed = div_zero_reg ? '1
                    : (neg_result ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0]);

  logic last_iter;
  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      opnd_reg     <= '0;
      is_div_reg   <= 1'b0;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
      busy_reg     <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (!op[2]) begin
              acc_reg      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
              opnd_reg     <= op[1] ? b_mag : a_mag;
              is_div_reg   <= op[1];
              sign_a_reg   <= a_neg;
              sign_b_reg   <= b_neg;
              div_zero_reg <= (b == '0);
              cnt_reg      <= '0;
              state_reg    <= S_RUN;
              busy_reg     <= 1'b1;
            end else if (op == OP_MTHI) begin
              hi_reg <= a;
            end else if (op == OP_MTLO) begin
              lo_reg <= a;
            end
          end
        end
        S_RUN: begin
          acc_reg <= is_div_reg ? div_next : mul_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (last_iter) begin
            state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          if (is_div_reg) begin
            hi_reg <= rem_fixed;
            lo_reg <= quot_fixed;
          end else begin
            hi_reg <= prod_fixed[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fixed[WIDTH-1:0];
          end
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
